// File: rtl/paula_uart_host_pkg.sv
// Shared definitions for the Paula-facing host UART: FSM state encoding and frame geometry.
package paula_uart_host_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with a registered head output; a write into an empty FIFO is visible the next tick.
module uart_byte_fifo #(
    parameter int unsigned AW = 4
) (
    input  logic       clk,
    input  logic       clk7_en,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] dout
);

    localparam int unsigned Depth = 1 << AW;

    logic [7:0]    mem [Depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(Depth));
    assign do_pop  = clk7_en && pop && !empty;
    // A full FIFO still accepts a push when the same tick frees a slot.
    assign do_push = clk7_en && push && (!full || do_pop);
    assign rd_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + (AW + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else if (clk7_en) begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            // Bypass when the incoming byte lands on the new head slot.
            if (count_next != '0) begin
                if (do_push && (wr_ptr == rd_next)) begin
                    dout <= din;
                end else begin
                    dout <= mem[rd_next];
                end
            end
        end
    end

endmodule

// File: rtl/paula_uart_host.sv
// Host-side 8N1 serial peer for Paula: buffered TX/RX byte streams with valid/ready handshakes.
module paula_uart_host
    import paula_uart_host_pkg::*;
#(
    parameter int unsigned FIFO_AW = 4,
    parameter int unsigned DIV_W   = 16
) (
    input  logic             clk,
    input  logic             clk7_en,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_frame_err,
    output logic             rx_overrun,
    input  logic             err_clr,
    output logic             ser_txd,
    input  logic             ser_rxd
);

    logic             tx_full;
    logic             tx_empty;
    logic [7:0]       tx_head;
    logic             tx_load;
    uart_state_e      tx_state;
    logic [DIV_W-1:0] tx_div;
    logic [DIV_W-1:0] tx_cnt;
    logic [7:0]       tx_shreg;
    logic [2:0]       tx_bit;

    logic             rx_full;
    logic             rx_empty;
    logic             rx_pop;
    logic             rx_push;
    logic [1:0]       rx_sync;
    logic             rx_prev;
    logic             rx_fall;
    uart_state_e      rx_state;
    logic [DIV_W-1:0] rx_div;
    logic [DIV_W-1:0] rx_cnt;
    logic [DIV_W-1:0] rx_half;
    logic [7:0]       rx_shreg;
    logic [2:0]       rx_bit;

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;

    uart_byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk     (clk),
        .clk7_en (clk7_en),
        .reset_n (reset_n),
        .push    (tx_valid),
        .din     (tx_data),
        .pop     (tx_load),
        .full    (tx_full),
        .empty   (tx_empty),
        .dout    (tx_head)
    );

    uart_byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk     (clk),
        .clk7_en (clk7_en),
        .reset_n (reset_n),
        .push    (rx_push),
        .din     (rx_shreg),
        .pop     (rx_pop),
        .full    (rx_full),
        .empty   (rx_empty),
        .dout    (rx_data)
    );

    // A frame starts from idle or directly at the end of a stop bit (no idle gap).
    assign tx_load = !tx_empty && ((tx_state == StIdle) || (tx_state == StStop && tx_cnt == '0));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_state <= StIdle;
            ser_txd  <= 1'b1;
            tx_div   <= '0;
            tx_cnt   <= '0;
            tx_shreg <= '0;
            tx_bit   <= '0;
        end else if (clk7_en) begin
            if (tx_load) begin
                tx_shreg <= tx_head;
                tx_div   <= baud_div;
                tx_cnt   <= baud_div;
                ser_txd  <= 1'b0;
                tx_state <= StStart;
            end else begin
                unique case (tx_state)
                    StIdle: tx_state <= StIdle;
                    StStart: begin
                        if (tx_cnt == '0) begin
                            tx_cnt   <= tx_div;
                            ser_txd  <= tx_shreg[0];
                            tx_bit   <= '0;
                            tx_state <= StData;
                        end else begin
                            tx_cnt <= tx_cnt - DIV_W'(1);
                        end
                    end
                    StData: begin
                        if (tx_cnt == '0) begin
                            tx_cnt <= tx_div;
                            if (tx_bit == 3'(DATA_BITS - 1)) begin
                                ser_txd  <= 1'b1;
                                tx_state <= StStop;
                            end else begin
                                tx_shreg <= tx_shreg >> 1;
                                ser_txd  <= tx_shreg[1];
                                tx_bit   <= tx_bit + 3'd1;
                            end
                        end else begin
                            tx_cnt <= tx_cnt - DIV_W'(1);
                        end
                    end
                    StStop: begin
                        if (tx_cnt == '0) begin
                            tx_state <= StIdle;
                        end else begin
                            tx_cnt <= tx_cnt - DIV_W'(1);
                        end
                    end
                    default: tx_state <= StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else if (clk7_en) begin
            rx_sync <= {rx_sync[0], ser_rxd};
            rx_prev <= rx_sync[1];
        end
    end

    assign rx_fall = rx_prev && !rx_sync[1];
    assign rx_half = baud_div >> 1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_state     <= StIdle;
            rx_div       <= '0;
            rx_cnt       <= '0;
            rx_shreg     <= '0;
            rx_bit       <= '0;
            rx_push      <= 1'b0;
            rx_frame_err <= 1'b0;
        end else if (clk7_en) begin
            rx_push <= 1'b0;
            if (err_clr) begin
                rx_frame_err <= 1'b0;
            end
            unique case (rx_state)
                StIdle: begin
                    if (rx_fall) begin
                        rx_div <= baud_div;
                        // With a zero half-bit offset the edge tick itself is the start sample.
                        if (rx_half == '0) begin
                            rx_cnt   <= baud_div;
                            rx_bit   <= '0;
                            rx_state <= StData;
                        end else begin
                            rx_cnt   <= rx_half - DIV_W'(1);
                            rx_state <= StStart;
                        end
                    end
                end
                StStart: begin
                    if (rx_cnt == '0) begin
                        if (!rx_sync[1]) begin
                            rx_cnt   <= rx_div;
                            rx_bit   <= '0;
                            rx_state <= StData;
                        end else begin
                            rx_state <= StIdle;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - DIV_W'(1);
                    end
                end
                StData: begin
                    if (rx_cnt == '0) begin
                        rx_shreg <= {rx_sync[1], rx_shreg[7:1]};
                        rx_cnt   <= rx_div;
                        if (rx_bit == 3'(DATA_BITS - 1)) begin
                            rx_state <= StStop;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - DIV_W'(1);
                    end
                end
                StStop: begin
                    if (rx_cnt == '0) begin
                        if (rx_sync[1]) begin
                            rx_push <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                        rx_state <= StIdle;
                    end else begin
                        rx_cnt <= rx_cnt - DIV_W'(1);
                    end
                end
                default: rx_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_overrun <= 1'b0;
        end else if (clk7_en) begin
            if (rx_push && rx_full && !rx_pop) begin
                rx_overrun <= 1'b1;
            end else if (err_clr) begin
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_paula_uart_host.sv
// Self-checking bench for paula_uart_host: TX waveform table, loopback with a queue model, corners.
module tb_paula_uart_host;

    logic        clk = 1'b0;
    logic        clk7_en = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] baud_div = 16'd3;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        rx_frame_err;
    logic        rx_overrun;
    logic        err_clr = 1'b0;
    logic        ser_txd;
    logic        ser_rxd;
    logic        loop = 1'b0;
    logic        rxd_drv = 1'b1;

    int checks = 0;
    int passes = 0;
    logic [7:0] src_q[$];

    assign ser_rxd = loop ? ser_txd : rxd_drv;

    always #5 clk = ~clk;

    paula_uart_host dut (
        .clk          (clk),
        .clk7_en      (clk7_en),
        .reset_n      (reset_n),
        .baud_div     (baud_div),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .err_clr      (err_clr),
        .ser_txd      (ser_txd),
        .ser_rxd      (ser_rxd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clk7_en tick followed by one disabled clock; returns on a negedge.
    task automatic step();
        @(negedge clk);
        clk7_en = 1'b1;
        @(negedge clk);
        clk7_en = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rxd_drv = f[b];
            repeat (int'(baud_div) + 1) step();
        end
        rxd_drv = 1'b1;
    endtask

    // Streams src_q through the TX->RX loop; the expected output is simply the same byte order.
    task automatic run_loop(input logic [15:0] div, input bit rand_ready);
        logic [7:0] exp_q[$];
        logic [7:0] tmp;
        int budget;
        loop     = 1'b1;
        baud_div = div;
        exp_q    = src_q;
        budget   = (src_q.size() + 3) * 10 * (int'(div) + 1) + 50;
        while (exp_q.size() > 0 && budget > 0) begin
            if (src_q.size() > 0 && tx_ready) begin
                tx_data  = src_q[0];
                tx_valid = 1'b1;
            end else begin
                tx_valid = 1'b0;
            end
            rx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rx_valid && rx_ready) begin
                check("loop_data", 32'(rx_data), 32'(exp_q[0]));
                tmp = exp_q.pop_front();
            end
            step();
            if (tx_valid) tmp = src_q.pop_front();
            budget--;
        end
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        check("loop_bytes_left", 32'(exp_q.size()), 32'd0);
        check("loop_flags", 32'({rx_overrun, rx_frame_err}), 32'd0);
        repeat (4) step();
        check("loop_rx_empty", 32'(rx_valid), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic [9:0]  frame;  // bit 0 goes out first
    } tx_vec_t;

    initial begin
        tx_vec_t    tv[5];
        logic [7:0] tmp;
        logic [7:0] exp16[$];
        int         ok;

        tv[0] = '{data: 8'hA5, div: 16'd3, frame: 10'b1101001010};
        tv[1] = '{data: 8'h00, div: 16'd0, frame: 10'b1000000000};
        tv[2] = '{data: 8'hFF, div: 16'd1, frame: 10'b1111111110};
        tv[3] = '{data: 8'h3C, div: 16'd2, frame: 10'b1001111000};
        tv[4] = '{data: 8'h81, div: 16'd0, frame: 10'b1100000010};

        repeat (3) step();
        check("rst_txd", 32'(ser_txd), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_flags", 32'({rx_overrun, rx_frame_err}), 32'd0);
        reset_n = 1'b1;
        repeat (2) step();

        // TX waveform table: every bit must hold its level for exactly div+1 ticks.
        for (int i = 0; i < 5; i++) begin
            baud_div = tv[i].div;
            push_tx(tv[i].data);
            check($sformatf("tx_v%0d_pre_idle", i), 32'(ser_txd), 32'd1);
            step();
            for (int b = 0; b < 10; b++) begin
                ok = 0;
                for (int k = 0; k <= int'(tv[i].div); k++) begin
                    if (ser_txd === tv[i].frame[b] && tx_ready === 1'b1) ok++;
                    step();
                end
                check($sformatf("tx_v%0d_bit%0d_ticks", i, b), 32'(ok), 32'(tv[i].div) + 1);
            end
            check($sformatf("tx_v%0d_post_idle", i), 32'(ser_txd), 32'd1);
            repeat (3) step();
        end

        // Fixed loopback sequence, then randomized ones against the queue model.
        src_q = '{8'h00, 8'hFF, 8'h3C};
        run_loop(16'd5, 1'b0);
        for (int t = 0; t < 6; t++) begin
            src_q.delete();
            repeat ($urandom_range(1, 12)) src_q.push_back(8'($urandom_range(0, 255)));
            run_loop(16'($urandom_range(0, 7)), 1'b1);
        end

        // Overrun: 17 frames into a 16-deep RX FIFO with no reader.
        baud_div = 16'd1;
        rx_ready = 1'b0;
        src_q.delete();
        for (int i = 0; i < 17; i++) src_q.push_back(8'(i * 13 + 1));
        exp16 = src_q;
        for (int k = 0; k < 17 * 20 + 80; k++) begin
            if (src_q.size() > 0 && tx_ready) begin
                tx_data  = src_q[0];
                tx_valid = 1'b1;
            end else begin
                tx_valid = 1'b0;
            end
            step();
            if (tx_valid) tmp = src_q.pop_front();
        end
        tx_valid = 1'b0;
        check("ovr_all_sent", 32'(src_q.size()), 32'd0);
        check("ovr_flag", 32'(rx_overrun), 32'd1);
        check("ovr_no_ferr", 32'(rx_frame_err), 32'd0);
        rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovr_drain%0d", i), 32'({rx_valid, rx_data}), 32'({1'b1, exp16[i]}));
            step();
        end
        rx_ready = 1'b0;
        check("ovr_drained_empty", 32'(rx_valid), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("ovr_clr", 32'(rx_overrun), 32'd0);
        loop = 1'b0;
        repeat (4) step();

        // Glitch shorter than half a bit must be ignored, then a real frame still decodes.
        baud_div = 16'd7;
        rxd_drv  = 1'b0;
        repeat (2) step();
        rxd_drv = 1'b1;
        repeat (40) step();
        check("glitch_no_push", 32'(rx_valid), 32'd0);
        check("glitch_no_flags", 32'({rx_overrun, rx_frame_err}), 32'd0);
        send_frame(8'h5A, 1'b1);
        repeat (6) step();
        check("glitch_after_frame", 32'({rx_valid, rx_data}), 32'h15A);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        check("glitch_after_pop", 32'(rx_valid), 32'd0);

        // Framing error: low stop bit sets the sticky flag and pushes nothing.
        baud_div = 16'd4;
        send_frame(8'h55, 1'b0);
        repeat (10) step();
        check("ferr_flag", 32'(rx_frame_err), 32'd1);
        check("ferr_no_push", 32'(rx_valid), 32'd0);
        check("ferr_no_ovr", 32'(rx_overrun), 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("ferr_clr", 32'(rx_frame_err), 32'd0);

        // Reset in the middle of data bit 4 of 0xA5, with a second byte still queued.
        baud_div = 16'd3;
        push_tx(8'hA5);
        push_tx(8'h3C);
        repeat (20) step();
        check("rst_mid_bit4", 32'(ser_txd), 32'd0);
        step();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_txd", 32'(ser_txd), 32'd1);
        check("rst_mid_tx_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (ser_txd === 1'b1) ok++;
        end
        check("rst_mid_silent", 32'(ok), 32'd60);
        check("rst_mid_rx_valid", 32'(rx_valid), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
